// File: rtl/bram_access_arbiter.sv
// Round-robin arbiter sharing one single-port image BRAM between the SPI transfer
// controller (port 0) and the PDI engine (port 1), with a burst limit and read-return tagging.
module bram_access_arbiter #(
    parameter int ADDR_W    = 17,
    parameter int DATA_W    = 8,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [1:0]        ch0,
    input  logic [1:0]        ch1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [1:0]        bram_channel,
    output logic              bram_we,
    output logic [DATA_W-1:0] bram_data_in,
    input  logic [DATA_W-1:0] bram_data_out,
    output logic [1:0]        owner
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   burst_cnt;
    logic [CNT_W-1:0]   burst_cnt_next;
    logic [CNT_W-1:0]   burst_inc;
    logic               last_owner;
    logic               last_owner_next;
    logic               acc0;
    logic               acc1;
    logic [RD_LAT:0][1:0] tag_pipe;

    assign acc0      = req0 & gnt0;
    assign acc1      = req1 & gnt1;
    assign burst_inc = (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            last_owner <= 1'b1;
        end else begin
            state      <= state_next;
            burst_cnt  <= burst_cnt_next;
            last_owner <= last_owner_next;
        end
    end

    // An owner keeps the BRAM until it stops requesting or, while the other port waits, hits the burst limit.
    always_comb begin
        state_next      = state;
        burst_cnt_next  = burst_cnt;
        last_owner_next = last_owner;
        case (state)
            IDLE: begin
                burst_cnt_next = '0;
                if (req0 && req1) state_next = last_owner ? OWN0 : OWN1;
                else if (req0)    state_next = OWN0;
                else if (req1)    state_next = OWN1;
            end
            OWN0: begin
                if (!req0) begin
                    state_next      = req1 ? OWN1 : IDLE;
                    last_owner_next = 1'b0;
                    burst_cnt_next  = '0;
                end else if (burst_inc == BURST_MAX && req1) begin
                    state_next      = OWN1;
                    last_owner_next = 1'b0;
                    burst_cnt_next  = '0;
                end else begin
                    burst_cnt_next  = burst_inc;
                end
            end
            OWN1: begin
                if (!req1) begin
                    state_next      = req0 ? OWN0 : IDLE;
                    last_owner_next = 1'b1;
                    burst_cnt_next  = '0;
                end else if (burst_inc == BURST_MAX && req0) begin
                    state_next      = OWN0;
                    last_owner_next = 1'b1;
                    burst_cnt_next  = '0;
                end else begin
                    burst_cnt_next  = burst_inc;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        owner = 2'b00;
        case (state)
            OWN0: begin
                gnt0  = 1'b1;
                owner = 2'b01;
            end
            OWN1: begin
                gnt1  = 1'b1;
                owner = 2'b10;
            end
            default: ;
        endcase
    end

    // Idle cycles keep the last address on the bus but never write.
    always_ff @(posedge clk) begin
        if (rst) begin
            bram_addr    <= '0;
            bram_channel <= '0;
            bram_we      <= 1'b0;
            bram_data_in <= '0;
        end else if (acc0) begin
            bram_addr    <= addr0;
            bram_channel <= ch0;
            bram_we      <= we0;
            bram_data_in <= wdata0;
        end else if (acc1) begin
            bram_addr    <= addr1;
            bram_channel <= ch1;
            bram_we      <= we1;
            bram_data_in <= wdata1;
        end else begin
            bram_we      <= 1'b0;
        end
    end

    // One stage for the command register plus RD_LAT stages matching the BRAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe[0] <= {acc1 & ~we1, acc0 & ~we0};
            for (int i = 1; i <= RD_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign rvalid0 = tag_pipe[RD_LAT][0];
    assign rvalid1 = tag_pipe[RD_LAT][1];
    assign rdata   = bram_data_out;

endmodule
